vx_ifetch_responder: RTL

//  Consumer end of the ifetch request interface driven by the warp scheduler.
//  - Accepts {wid, tmask, PC} fetch requests and issues word-addressed I-cache reads tagged by wid.
//  - Keeps per-warp request metadata and pairs each I-cache response with it.
//  - Returns {wid, tmask, PC, instr} to decode through a registered output stage.
//  - Sits between the warp scheduler and the decode stage inside each core.

---
 rtl/vx_ifetch_responder_if.sv | 82 ++++++++
 rtl/vx_ifetch_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vx_ifetch_responder_if.sv
// Bundle of the ifetch request, I-cache read/response and decode-facing channels.
// The responder binds to the slave modport; the surrounding core drives the master side.
interface vx_ifetch_responder_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4
);
  localparam int unsigned NwBits = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  // Warp scheduler -> responder
  logic                   ifreq_valid;
  logic                   ifreq_ready;
  logic [NwBits-1:0]      ifreq_wid;
  logic [NUM_THREADS-1:0] ifreq_tmask;
  logic [31:0]            ifreq_pc;

  // Responder <-> I-cache
  logic                   icache_req_valid;
  logic                   icache_req_ready;
  logic [29:0]            icache_req_addr;
  logic [NwBits-1:0]      icache_req_tag;
  logic                   icache_rsp_valid;
  logic                   icache_rsp_ready;
  logic [31:0]            icache_rsp_data;
  logic [NwBits-1:0]      icache_rsp_tag;

  // Responder -> decode
  logic                   ifrsp_valid;
  logic                   ifrsp_ready;
  logic [NwBits-1:0]      ifrsp_wid;
  logic [NUM_THREADS-1:0] ifrsp_tmask;
  logic [31:0]            ifrsp_pc;
  logic [31:0]            ifrsp_instr;

  logic                   busy;

  modport slave (
    input  ifreq_valid,
    input  ifreq_wid,
    input  ifreq_tmask,
    input  ifreq_pc,
    output ifreq_ready,
    output icache_req_valid,
    input  icache_req_ready,
    output icache_req_addr,
    output icache_req_tag,
    input  icache_rsp_valid,
    output icache_rsp_ready,
    input  icache_rsp_data,
    input  icache_rsp_tag,
    output ifrsp_valid,
    input  ifrsp_ready,
    output ifrsp_wid,
    output ifrsp_tmask,
    output ifrsp_pc,
    output ifrsp_instr,
    output busy
  );

  modport master (
    output ifreq_valid,
    output ifreq_wid,
    output ifreq_tmask,
    output ifreq_pc,
    input  ifreq_ready,
    input  icache_req_valid,
    output icache_req_ready,
    input  icache_req_addr,
    input  icache_req_tag,
    output icache_rsp_valid,
    input  icache_rsp_ready,
    output icache_rsp_data,
    output icache_rsp_tag,
    input  ifrsp_valid,
    output ifrsp_ready,
    input  ifrsp_wid,
    input  ifrsp_tmask,
    input  ifrsp_pc,
    input  ifrsp_instr,
    input  busy
  );

endinterface

// File: rtl/vx_ifetch_responder.sv
// Ifetch consumer: issues warp-tagged I-cache reads and pairs responses with per-warp metadata.
// Optional issue/latency performance counters are built when IFETCH_PERF_EN is defined.
module vx_ifetch_responder #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned MAX_PENDING = NUM_WARPS
) (
  input  logic                clk,
  input  logic                reset,
`ifdef IFETCH_PERF_EN
  output logic [43:0]         perf_ifetch_reqs,
  output logic [43:0]         perf_ifetch_lat,
`endif
  vx_ifetch_responder_if.slave bus
);

  localparam int unsigned NwBits   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  // Tables span every encodable wid so tag indexing never needs a range check.
  localparam int unsigned NumSlots = 1 << NwBits;
  localparam int unsigned CntW     = $clog2(MAX_PENDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PENDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [NumSlots-1:0]    pending_q, pending_d;
  logic [CntW-1:0]        pend_cnt_q, pend_cnt_d;
  logic [NUM_THREADS-1:0] meta_tmask_q [NumSlots];
  logic [31:0]            meta_pc_q    [NumSlots];

  logic                   out_valid_q, out_valid_d;
  logic [NwBits-1:0]      out_wid_q;
  logic [NUM_THREADS-1:0] out_tmask_q;
  logic [31:0]            out_pc_q;
  logic [31:0]            out_instr_q;

  logic can_issue;
  logic issue_fire;
  logic rsp_ready;
  logic rsp_fire;
  logic rsp_legal;

  // Handshake decode
  always_comb begin
    can_issue  = !pending_q[bus.ifreq_wid] && (pend_cnt_q < MaxCnt);
    issue_fire = bus.ifreq_valid && bus.icache_req_ready && can_issue;
    rsp_ready  = !out_valid_q || bus.ifrsp_ready;
    rsp_fire   = bus.icache_rsp_valid && rsp_ready;
    rsp_legal  = pending_q[bus.icache_rsp_tag];
  end

  // A same-wid issue is already blocked by can_issue, so set and clear never collide.
  always_comb begin
    pending_d   = pending_q;
    pend_cnt_d  = pend_cnt_q;
    out_valid_d = out_valid_q;
    if (rsp_fire && rsp_legal) begin
      pending_d[bus.icache_rsp_tag] = 1'b0;
      pend_cnt_d                    = pend_cnt_d - CntOne;
    end
    if (issue_fire) begin
      pending_d[bus.ifreq_wid] = 1'b1;
      pend_cnt_d               = pend_cnt_d + CntOne;
    end
    if (rsp_fire) begin
      out_valid_d = 1'b1;
    end else if (bus.ifrsp_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q   <= '0;
      pend_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_cnt_q  <= pend_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Metadata and payload registers carry no reset; validity is tracked above.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      meta_tmask_q[bus.ifreq_wid] <= bus.ifreq_tmask;
      meta_pc_q[bus.ifreq_wid]    <= bus.ifreq_pc;
    end
    if (rsp_fire) begin
      out_wid_q   <= bus.icache_rsp_tag;
      out_tmask_q <= meta_tmask_q[bus.icache_rsp_tag];
      out_pc_q    <= meta_pc_q[bus.icache_rsp_tag];
      out_instr_q <= bus.icache_rsp_data;
    end
  end

  assign bus.ifreq_ready      = bus.icache_req_ready && can_issue;
  assign bus.icache_req_valid = bus.ifreq_valid && can_issue;
  assign bus.icache_req_addr  = bus.ifreq_pc[31:2];
  assign bus.icache_req_tag   = bus.ifreq_wid;
  assign bus.icache_rsp_ready = rsp_ready;
  assign bus.ifrsp_valid      = out_valid_q;
  assign bus.ifrsp_wid        = out_wid_q;
  assign bus.ifrsp_tmask      = out_tmask_q;
  assign bus.ifrsp_pc         = out_pc_q;
  assign bus.ifrsp_instr      = out_instr_q;
  assign bus.busy             = (pend_cnt_q != '0) || out_valid_q;

`ifdef IFETCH_PERF_EN
  logic [43:0] perf_reqs_q;
  logic [43:0] perf_lat_q;

  // Latency accumulates outstanding reads per cycle; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_reqs_q <= '0;
      perf_lat_q  <= '0;
    end else begin
      if (issue_fire) begin
        perf_reqs_q <= perf_reqs_q + 44'd1;
      end
      perf_lat_q <= perf_lat_q + 44'(pend_cnt_q);
    end
  end

  assign perf_ifetch_reqs = perf_reqs_q;
  assign perf_ifetch_lat  = perf_lat_q;
`endif

  illegal_tag_a: assert property (@(posedge clk) disable iff (!reset)
    rsp_fire |-> rsp_legal);

  pc_aligned_a: assert property (@(posedge clk) disable iff (!reset)
    bus.ifreq_valid |-> (bus.ifreq_pc[1:0] == 2'b00));

endmodule
